// File: rtl/vx_tcu_drl_kstep_ctrl_pkg.sv
// rtl/vx_tcu_drl_kstep_ctrl_pkg.sv - shared types and format helpers for the TCU DRL K-step controller
//
// Purpose: format IDs, controller state encoding, and per-format step sizing
//          shared by vx_tcu_drl_kstep_ctrl and vx_tcu_drl_kmask_gen.
// Ports:   none (package).

package vx_tcu_drl_kstep_ctrl_pkg;

  // Format identifiers carried on cmd_fmt / dp_fmt.
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_FP8_ID  = 4'd3;
  localparam logic [3:0] TCU_BF8_ID  = 4'd4;
  localparam logic [3:0] TCU_TF32_ID = 4'd5;
  localparam logic [3:0] TCU_I8_ID   = 4'd9;
  localparam logic [3:0] TCU_U8_ID   = 4'd10;
  localparam logic [3:0] TCU_I4_ID   = 4'd11;
  localparam logic [3:0] TCU_U4_ID   = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } kstep_state_t;

  // K elements consumed by one datapath step; 0 marks an unsupported format.
  function automatic int tcu_elems_per_step(input logic [3:0] fmt, input int n);
    case (fmt)
      TCU_TF32_ID:                                   return n;
      TCU_FP16_ID, TCU_BF16_ID:                      return 2 * n;
      TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID:  return 4 * n;
      TCU_I4_ID, TCU_U4_ID:                          return 8 * n;
      default:                                       return 0;
    endcase
  endfunction

  function automatic logic tcu_fmt_valid(input logic [3:0] fmt);
    case (fmt)
      TCU_TF32_ID, TCU_FP16_ID, TCU_BF16_ID,
      TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID,
      TCU_I4_ID, TCU_U4_ID:                          return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vx_tcu_drl_kstep_ctrl_kmask_gen.sv
// rtl/vx_tcu_drl_kstep_ctrl_kmask_gen.sv - combinational lane mask and last-step flag for one K step
//
// Purpose: for step index `step` of a tile with `k` elements in format `fmt`,
//          produce the per-lane valid mask and whether this is the final step.
// Ports:
//   fmt      in  [3:0]       format ID
//   k        in  [KW-1:0]    total K elements of the tile
//   step     in  [KW-1:0]    current step index
//   vld_mask out [MAX_IN-1:0] lane l set iff l < EPS and step*EPS + l < k
//   last     out             no elements remain beyond this step

module vx_tcu_drl_kmask_gen
  import vx_tcu_drl_kstep_ctrl_pkg::*;
#(
  parameter int N      = 2,
  parameter int MAX_IN = 8 * N,
  parameter int KW     = 16
) (
  input  logic [3:0]        fmt,
  input  logic [KW-1:0]     k,
  input  logic [KW-1:0]     step,
  output logic [MAX_IN-1:0] vld_mask,
  output logic              last
);

  // One extra bit so that remaining never wraps, even for k = 2^KW-1.
  logic [KW:0] eps;
  logic [KW:0] base;
  logic [KW:0] remaining;

  always_comb begin
    eps       = (KW+1)'(tcu_elems_per_step(fmt, N));
    base      = (KW+1)'({1'b0, step} * eps);
    remaining = {1'b0, k} - base;
    // K=0 lands here with remaining=0, so step 0 is also the last one.
    last      = (remaining <= eps);
    vld_mask  = '0;
    for (int l = 0; l < MAX_IN; l++) begin
      vld_mask[l] = ((KW+1)'(l) < eps) && ((KW+1)'(l) < remaining);
    end
  end

endmodule

// File: rtl/vx_tcu_drl_kstep_ctrl.sv
// rtl/vx_tcu_drl_kstep_ctrl.sv - K-dimension step sequencer for the TCU DRL dot-product datapath
//
// Purpose: accepts one tile command, issues ceil(K/EPS) datapath steps (at
//          least one) with lane masks and first/last flags, throttles against
//          MAX_OUTSTANDING in-flight steps and reports completion after drain.
// Optional: VX_TCU_DRL_KSTEP_PERF_EN adds perf_issue_cnt, perf_stall_cnt and
//          perf_throttle_cnt free-running 32-bit counters.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only when idle)
//   cmd_fmt, cmd_k, cmd_tag          format, K element count, tag
//   rd_addr, dp_valid/dp_ready       step index and issue handshake
//   dp_fmt, dp_vld_mask              per-step format and lane mask
//   dp_first, dp_last                first / final step of tile
//   dp_resp_valid                    one step result left the datapath
//   done_valid/done_ready            completion handshake
//   done_tag, done_err               tag echo, unsupported-format flag
//   busy                             controller not idle

module vx_tcu_drl_kstep_ctrl
  import vx_tcu_drl_kstep_ctrl_pkg::*;
#(
  parameter int N               = 2,
  parameter int MAX_IN          = 8 * N,
  parameter int KW              = 16,
  parameter int TAGW            = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fmt,
  input  logic [KW-1:0]     cmd_k,
  input  logic [TAGW-1:0]   cmd_tag,
  output logic [KW-1:0]     rd_addr,
  output logic              dp_valid,
  input  logic              dp_ready,
  output logic [3:0]        dp_fmt,
  output logic [MAX_IN-1:0] dp_vld_mask,
  output logic              dp_first,
  output logic              dp_last,
  input  logic              dp_resp_valid,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [TAGW-1:0]   done_tag,
  output logic              done_err,
  output logic              busy
`ifdef VX_TCU_DRL_KSTEP_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_throttle_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE_OUT = OW'(1);

  kstep_state_t      state;
  kstep_state_t      state_n;

  logic [3:0]        fmt_r;
  logic [KW-1:0]     k_r;
  logic [TAGW-1:0]   tag_r;
  logic [KW-1:0]     step_r;
  logic              err_r;
  logic [OW-1:0]     outstanding;

  logic              cmd_fire;
  logic              can_issue;
  logic              issue_fire;
  logic              resp_eff;
  logic [MAX_IN-1:0] gen_mask;
  logic              gen_last;

  vx_tcu_drl_kmask_gen #(
    .N      (N),
    .MAX_IN (MAX_IN),
    .KW     (KW)
  ) u_kmask_gen (
    .fmt      (fmt_r),
    .k        (k_r),
    .step     (step_r),
    .vld_mask (gen_mask),
    .last     (gen_last)
  );

  // dp_valid depends only on registered state, never on dp_ready, so it
  // cannot drop while a step is stalled: outstanding only rises on a fire.
  assign can_issue  = (state == ISSUE) && (outstanding < MAX_OUT);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign issue_fire = dp_valid && dp_ready;
  // Responses arriving with nothing in flight (e.g. after reset) are dropped.
  assign resp_eff   = dp_resp_valid && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    dp_valid   = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_n = tcu_fmt_valid(cmd_fmt) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        dp_valid = can_issue;
        if (can_issue && dp_ready && gen_last) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        // A response landing this cycle on the last in-flight step counts.
        if ((outstanding == '0) || ((outstanding == ONE_OUT) && dp_resp_valid)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Step outputs are forced to zero outside an active issue request.
  assign busy        = (state != IDLE);
  assign rd_addr     = dp_valid ? step_r : '0;
  assign dp_fmt      = dp_valid ? fmt_r : '0;
  assign dp_vld_mask = dp_valid ? gen_mask : '0;
  assign dp_first    = dp_valid && (step_r == '0);
  assign dp_last     = dp_valid && gen_last;
  assign done_tag    = tag_r;
  assign done_err    = done_valid && err_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_r       <= '0;
      k_r         <= '0;
      tag_r       <= '0;
      step_r      <= '0;
      err_r       <= 1'b0;
      outstanding <= '0;
    end else begin
      if (cmd_fire) begin
        fmt_r  <= cmd_fmt;
        k_r    <= cmd_k;
        tag_r  <= cmd_tag;
        step_r <= '0;
        err_r  <= !tcu_fmt_valid(cmd_fmt);
      end else if (issue_fire) begin
        step_r <= step_r + KW'(1);
      end

      case ({issue_fire, resp_eff})
        2'b10:   outstanding <= outstanding + ONE_OUT;
        2'b01:   outstanding <= outstanding - ONE_OUT;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef VX_TCU_DRL_KSTEP_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_cnt    <= '0;
      perf_stall_cnt    <= '0;
      perf_throttle_cnt <= '0;
    end else begin
      if (issue_fire) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if (dp_valid && !dp_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if ((state == ISSUE) && !can_issue) begin
        perf_throttle_cnt <= perf_throttle_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/vx_tcu_drl_kstep_ctrl.md
Name: VX_tcu_drl_kstep_ctrl

Overview:
K-dimension step sequencer for the TCU DRL dot-product datapath (shared mantissa/integer multiplier plus accumulate stage). It accepts one tile command (format, K element count, tag) and walks the operand buffer one datapath step at a time. Per step it generates the per-lane valid mask, first/last flags and the operand read address. It throttles issue against pipeline occupancy and signals completion once the final result has drained.

Parameters:
N, 2, 32-bit operand words per a_row/b_col (matches datapath N)
MAX_IN, 8*N, vld_mask width (lanes at finest granularity, int4)
KW, 16, width of K element count
TAGW, 4, command tag width
MAX_OUTSTANDING, 4, maximum issued-but-unreturned datapath steps

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, can accept
cmd_fmt  in  4  format ID (VX_tcu_pkg TCU_*_ID)
cmd_k  in  KW  total K elements
cmd_tag  in  TAGW  returned with done
rd_addr  out  KW  operand buffer step index, valid while dp_valid
dp_valid  out  1  step issue request
dp_ready  in  1  datapath accepts step
dp_fmt  out  4  format for this step (fmt_s)
dp_vld_mask  out  MAX_IN  lane valid mask
dp_first  out  1  first step: accumulator seeded from c_val
dp_last  out  1  final step of tile
dp_resp_valid  in  1  one step result leaves datapath pipeline
done_valid  out  1  tile complete
done_ready  in  1  done consumed
done_tag  out  TAGW  tag of completed tile
done_err  out  1  unsupported format; nothing issued
busy  out  1  state != IDLE

Behaviour:
- Reset values: cmd_ready=1, dp_valid=0, done_valid=0, done_err=0, busy=0, rd_addr=0, dp_vld_mask=0, dp_first=0, dp_last=0, outstanding=0, state=IDLE. Reset mid-tile abandons the tile. Late dp_resp_valid pulses after reset are ignored; outstanding saturates at 0.
- Elements per step (EPS): TF32 = N; FP16/BF16 = 2N; FP8/BF8/I8/U8 = 4N; I4/U4 = 8N. Steps = ceil(K/EPS). K=0 issues exactly one step with mask 0 and first=last=1, so the result is the C passthrough.
- Mask: lane l (l < EPS) is set iff step*EPS + l < K. Lanes l >= EPS are always 0. Arithmetic on remaining = K - step*EPS uses KW+1 bits, so there is no wrap at K=2^KW-1.
- FSM:
  - IDLE: cmd fire → latch fmt/k/tag, step=0. Valid fmt → ISSUE; invalid fmt → DONE with err=1.
  - ISSUE: dp_valid=1 iff outstanding < MAX_OUTSTANDING. On dp_valid&&dp_ready, step++. Firing with dp_last → DRAIN.
  - DRAIN: wait until outstanding==0 (including a response in the same cycle) → DONE.
  - DONE: done_valid=1; done_ready → IDLE.
- Latency: cmd fire at cycle T → first dp_valid at T+1. After the last response, done_valid is asserted the following cycle.
- dp_valid, rd_addr, mask, first, last and fmt are held stable while dp_valid && !dp_ready. dp_valid is never withdrawn once asserted.
- Outstanding counter: +1 on issue fire, -1 on dp_resp_valid, unchanged when both occur in one cycle. Width $clog2(MAX_OUTSTANDING+1).
- cmd_ready=1 only in IDLE. There is no command queueing.

Optional Feature:
VX_TCU_DRL_KSTEP_PERF_EN
- Defined: adds outputs perf_issue_cnt[31:0] (issue fires), perf_stall_cnt[31:0] (cycles with dp_valid && !dp_ready), and perf_throttle_cnt[31:0] (ISSUE cycles blocked by MAX_OUTSTANDING). All three are free-running, wrap at 2^32 and clear on reset.
- Undefined: these ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- VX_tcu_pkg: kstep_state_t enum {IDLE, ISSUE, DRAIN, DONE}; function tcu_elems_per_step(fmt, N); function tcu_fmt_valid(fmt).
- One sub-module: VX_tcu_drl_kmask_gen (combinational). Inputs fmt, K, step; outputs vld_mask, last.

Test Plan:
1. N=2, FP16, K=10 → 3 issues: rd_addr 0/1/2, masks 0x000F/0x000F/0x0003, first on step 0 only, last on step 2 only. Done after 3 responses, done_tag echoed.
2. I8, K=0 → single issue with mask 0x0000, first=last=1; done_err=0.
3. TF32, K=6, dp_ready low 3 cycles on step 1 → step-1 outputs held constant, no step skipped or duplicated; exactly 3 issues.
4. MAX_OUTSTANDING=2, I4, K=64 (4 steps), responses withheld → dp_valid drops after 2 issues. One response → exactly one more issue. Issue and response in the same cycle keeps outstanding at 2.
5. Reset asserted in ISSUE after 1 issue → next cycle cmd_ready=1, dp_valid=0, busy=0. A following FP8, K=8 command issues a single full step with mask 0x00FF.
6. Invalid fmt 4'hF → no dp_valid, done_valid with done_err=1; cmd_ready stays low until done_ready.
